// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         CNT_W             = 16;

endpackage

// File: rtl/prog_loader_byte_to_word_packer.sv
// Packs little-endian bytes into 32-bit words; word_valid pulses one cycle after the 4th byte.
module byte_to_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  byte_idx,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] partial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx   <= 2'd0;
      partial    <= 24'd0;
      word_valid <= 1'b0;
      word_data  <= 32'd0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= 2'd0;
        partial  <= 24'd0;
      end else if (byte_valid) begin
        // bytes shift in from the top so byte 0 ends up in bits [7:0]
        if (byte_idx == 2'd3) begin
          word_valid <= 1'b1;
          word_data  <= {byte_data, partial};
        end else begin
          partial <= {byte_data, partial[23:8]};
        end
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader into instruction memory; holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst_n,
  output logic        done,
  output logic        err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = S_CSUM;
`else
  localparam state_t S_FINAL = S_DONE;
`endif

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] count_next;
  logic [1:0]       byte_idx;
  logic             accept;
  logic             rearm;
  logic             pack_clear;
  logic             word_valid;
  logic [31:0]      word_data;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign accept     = rx_valid && rx_ready;
  assign rearm      = start && (state == S_DONE || state == S_ERR);
  assign pack_clear = rearm || (state == S_IDLE);
  assign count_next = {rx_data, count[7:0]};

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .byte_valid (accept && state == S_DATA),
    .byte_data  (rx_data),
    .byte_idx   (byte_idx),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept && rx_data == SYNC_BYTE) state_next = S_LEN0;
      S_LEN0: if (accept) state_next = S_LEN1;
      S_LEN1: if (accept) begin
        if (count_next > MAX_CNT)        state_next = S_ERR;
        else if (count_next == '0)       state_next = S_FINAL;
        else                             state_next = S_DATA;
      end
      // leave on the 4th byte of the last word; its write lands the following cycle
      S_DATA: if (accept && byte_idx == 2'd3 && word_idx == count - CNT_W'(1))
        state_next = S_FINAL;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERR;
`endif
      S_DONE, S_ERR: if (start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready  = !(state == S_DONE || state == S_ERR);
    cpu_rst_n = (state == S_DONE);
    done      = (state == S_DONE);
    err       = (state == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      word_idx <= '0;
    end else if (rearm || state == S_IDLE) begin
      count    <= '0;
      word_idx <= '0;
    end else begin
      if (accept && state == S_LEN0) count[7:0]  <= rx_data;
      if (accept && state == S_LEN1) count[15:8] <= rx_data;
      if (word_valid) word_idx <= word_idx + CNT_W'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              csum <= 8'd0;
    else if (rearm || state == S_IDLE)    csum <= 8'd0;
    else if (accept && state == S_DATA)   csum <= csum ^ rx_data;
  end
`endif

  assign imem_we    = word_valid;
  assign imem_wdata = word_data;
  assign imem_addr  = BASE_ADDR + {14'd0, word_idx, 2'b00};

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes queued at stimulus, checked on imem_we.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  prog_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && imem_we) begin
      logic [63:0] exp;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL imem_write_unexpected: got addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== exp) begin
          n_bad++;
          $display("FAIL imem_write: got addr=%h data=%h, required addr=%h data=%h",
                   imem_addr, imem_wdata, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends sync, count and words; queues expected writes; optional checksum corruption
  task automatic send_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input bit bad_csum, input int gap);
    logic [31:0] w;
    logic [7:0]  cs;
    cs = 8'h00;
    send_byte(8'hA5, 0);
    send_byte(8'(n), 0);
    send_byte(8'(n >> 8), 0);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : (i == 1) ? w1 : w2;
      exp_q.push_back({32'(4 * i), w});
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], gap);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad_csum ? ~cs : cs, 0);
`else
    if (bad_csum) cs = ~cs;
`endif
  endtask

  task automatic check_status(input string name, input logic e_done, input logic e_err,
                              input logic e_cpu, input logic e_ready);
    n_cmp++;
    if ({done, err, cpu_rst_n, rx_ready} !== {e_done, e_err, e_cpu, e_ready}) begin
      n_bad++;
      $display("FAIL %s: got done=%b err=%b cpu_rst_n=%b rx_ready=%b, required %b %b %b %b",
               name, done, err, cpu_rst_n, rx_ready, e_done, e_err, e_cpu, e_ready);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check_status("reset_status", 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b0, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_imem: got we=%b addr=%h data=%h, required 0 0 0", imem_we, imem_addr, imem_wdata);
    end
  endtask

  task automatic test_basic();
    send_frame(3, 32'h00A00093, 32'h01400113, 32'h002081B3, 1'b0, 0);
    check_status("basic_done", 1'b1, 1'b0, 1'b1, 1'b0);
    check_drained("basic_writes");
  endtask

  task automatic test_restart();
    pulse_start();
    check_status("restart_cleared", 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(1, 32'h00000063, 32'h0, 32'h0, 1'b0, 0);
    check_status("restart_done", 1'b1, 1'b0, 1'b1, 1'b0);
    check_drained("restart_writes");
  endtask

  task automatic test_bad_checksum();
`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send_frame(3, 32'h00A00093, 32'h01400113, 32'h002081B3, 1'b1, 0);
    check_status("bad_csum_err", 1'b0, 1'b1, 1'b0, 1'b0);
    check_drained("bad_csum_writes");
`endif
  endtask

  task automatic test_overcount();
    pulse_start();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check_status("overcount_err", 1'b0, 1'b1, 1'b0, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    check_drained("overcount_no_writes");
  endtask

  task automatic test_junk_gaps();
    pulse_start();
    send_byte(8'h00, 1);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 2);
    send_frame(3, 32'h00A00093, 32'h01400113, 32'h002081B3, 1'b0, 2);
    check_status("junk_gaps_done", 1'b1, 1'b0, 1'b1, 1'b0);
    check_drained("junk_gaps_writes");
  endtask

  task automatic test_reset_mid();
    pulse_start();
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    exp_q.push_back({32'h0, 32'h11223344});
    exp_q.push_back({32'h4, 32'hA5A5A5A5});
    for (int k = 0; k < 4; k++) send_byte(8'(32'h11223344 >> (8 * k)), 0);
    for (int k = 0; k < 4; k++) send_byte(8'hA5, 0);
    @(posedge clk); #1;
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({imem_we, cpu_rst_n, done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got we=%b cpu_rst_n=%b done=%b, required 0 0 0", imem_we, cpu_rst_n, done);
    end
    @(posedge clk); #1 rst = 1'b0;
    check_status("reset_mid_idle", 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(3, 32'hDEADBEEF, 32'h00000013, 32'hCAFEF00D, 1'b0, 0);
    check_status("reset_mid_done", 1'b1, 1'b0, 1'b1, 1'b0);
    check_drained("reset_mid_writes");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_bad_checksum();
    test_overcount();
    test_junk_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
